// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

   // Default bubble presented to decode when no fetched instruction is available (addi x0,x0,0).
   localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

   // Byte distance between consecutive sequential fetches.
   localparam logic [31:0] PC_INC_C = 32'd4;

   // One fetched instruction together with the byte address it came from.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Force word alignment; the low two address bits carry no meaning for 32-bit fetch.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular queue of fetched {pc, instr} entries. DEPTH is expected to be a
// power of two (2 or 4) so the pointers wrap naturally. A flush empties the queue
// and takes priority over any push or pop in the same cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  fetch_entry_t wr_entry,
   output fetch_entry_t rd_entry,
   output logic         full,
   output logic         empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   fetch_entry_t  store [DEPTH];

   assign full     = (count == CNT_MAX);
   assign empty    = (count == '0);
   assign rd_entry = store[rd_ptr];

   // A push into a full queue is only accepted when the head leaves in the same cycle.
   assign do_push  = push && (!full || pop);
   assign do_pop   = pop && !empty;

   // Pointer and occupancy tracking; flush returns everything to the empty state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Entry storage needs no reset: slots are only visible once count covers them.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         store[wr_ptr] <= wr_entry;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one word-aligned fetch per cycle
// to a combinational instruction memory, and buffers results in a short queue that
// feeds decode. A redirect flushes the queue and restarts fetch at the target.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_C,
   parameter int          QDEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc
);

   logic [31:0]  pc_q;
   logic [31:0]  pc_d;
   logic         q_full;
   logic         q_empty;
   logic         q_push;
   logic         q_pop;
   fetch_entry_t q_head;
   fetch_entry_t q_wr;

   // The address goes straight out of the PC register, so decode back-pressure only
   // reaches imem_addr one cycle later through the push enable.
   assign imem_addr = align_pc(pc_q);

   assign out_valid = !q_empty;

   // A redirect wins over everything: nothing is consumed or fetched on that edge.
   assign q_pop  = out_valid && out_ready && !redirect_valid;
   assign q_push = !redirect_valid && (!q_full || q_pop);

   assign q_wr.pc    = imem_addr;
   assign q_wr.instr = imem_instr;

   fetch_fifo #(
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect_valid),
      .push     (q_push),
      .pop      (q_pop),
      .wr_entry (q_wr),
      .rd_entry (q_head),
      .full     (q_full),
      .empty    (q_empty)
   );

   // Next PC: redirect target, sequential advance on a successful fetch, else hold.
   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = align_pc(redirect_pc);
      end else if (q_push) begin
         pc_d = pc_q + PC_INC_C;
      end
   end

   // PC register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= align_pc(RESET_PC);
      end else begin
         pc_q <= pc_d;
      end
   end

   // Decode sees a clean bubble whenever the queue is empty rather than stale storage.
   always_comb begin
      out_pc    = 32'h0;
      out_instr = NOP_INSTR;
      if (!q_empty) begin
         out_pc    = q_head.pc;
         out_instr = q_head.instr;
      end
   end

endmodule
